// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle logic/arith/shift/compare ops plus iterative
// shift-add MUL and restoring DIVU/REMU, one operation in flight.
module alu_mc #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_DIVU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  logic [1:0]         r_state;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;

  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_single;
  logic               w_illegal;
  logic               w_iter_op;
  logic [WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_final;
  logic               w_last;

  assign w_shamt   = in_b[SHAMT_W-1:0];
  assign w_iter_op = (in_op == OP_MUL) || (in_op == OP_DIVU) || (in_op == OP_REMU);

  always_comb begin
    w_single  = '0;
    w_illegal = 1'b0;
    case (in_op)
      OP_AND:  w_single = in_a & in_b;
      OP_OR:   w_single = in_a | in_b;
      OP_ADD:  w_single = in_a + in_b;
      OP_SUB:  w_single = in_a - in_b;
      OP_XOR:  w_single = in_a ^ in_b;
      OP_SLL:  w_single = in_a << w_shamt;
      OP_SRL:  w_single = in_a >> w_shamt;
      OP_SRA:  w_single = $unsigned($signed(in_a) >>> w_shamt);
      OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_MUL, OP_DIVU, OP_REMU: w_single = '0;
      default: w_illegal = 1'b1;
    endcase
  end

  // MUL: r_x = shifted multiplicand, r_y = multiplier. DIV: r_x = dividend shifting into
  // the quotient, r_y = divisor, r_acc = partial remainder. Zero divisor falls out naturally.
  assign w_mul_acc = r_y[0] ? (r_acc + r_x) : r_acc;
  assign w_rem_sh  = {r_acc, r_x[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_y};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_div_rem = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_div_quo = {r_x[WIDTH-2:0], w_ge};
  assign w_last    = (r_cnt == SHAMT_W'(WIDTH - 1));

  always_comb begin
    w_final = w_div_rem;
    if (r_op == OP_MUL)       w_final = w_mul_acc;
    else if (r_op == OP_DIVU) w_final = w_div_quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= in_op;
            r_x   <= in_a;
            r_y   <= in_b;
            r_acc <= '0;
            r_cnt <= '0;
            if (w_iter_op) begin
              r_state <= S_BUSY;
            end else begin
              r_result  <= w_single;
              r_zero    <= (w_single == '0);
              r_illegal <= w_illegal;
              r_state   <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (r_op == OP_MUL) begin
            r_acc <= w_mul_acc;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
          end else begin
            r_acc <= w_div_rem;
            r_x   <= w_div_quo;
          end
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result  <= w_final;
            r_zero    <= (w_final == '0);
            r_illegal <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_result  = r_result;
  assign out_zero    = r_zero;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors, reset/flush/backpressure scenarios and
// random ops against an arithmetic reference model, on a 64-bit and an 8-bit instance.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_zero;
  logic        out_illegal;

  logic        flush8 = 1'b0;
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [3:0]  in_op8 = '0;
  logic [7:0]  in_a8 = '0;
  logic [7:0]  in_b8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [7:0]  out_result8;
  logic        out_zero8;
  logic        out_illegal8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_op(in_op8), .in_a(in_a8), .in_b(in_b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_result(out_result8), .out_zero(out_zero8),
    .out_illegal(out_illegal8)
  );

  // Reference: {illegal, result} computed on w-bit values with plain arithmetic.
  function automatic logic [64:0] model(input int w, input logic [3:0] op,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, sa, sb, r;
    int sh;
    logic ill;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a_in & mask;
    b = b_in & mask;
    sa = a[w-1] ? (a | ~mask) : a;
    sb = b[w-1] ? (b | ~mask) : b;
    sh = int'(b % 64'(w));
    ill = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd6:  r = a - b;
      4'd4:  r = a ^ b;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: r = $signed(sa) >>> sh;
      4'd7:  r = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
      4'd3:  r = a * b;
      4'd5:  r = (b == 0) ? mask : a / b;
      4'd11: r = (b == 0) ? a : a % b;
      default: begin r = 64'd0; ill = 1'b1; end
    endcase
    return {ill, r & mask};
  endfunction

  function automatic int exp_edges(input int w, input logic [3:0] op);
    return (op == 4'd3 || op == 4'd5 || op == 4'd11) ? w : 0;
  endfunction

  // Issue one op from IDLE, count edges after the accept edge until out_valid, then consume.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output logic z, output logic ill,
                        output int edges);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 4'($urandom);
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    res = out_result; z = out_zero; ill = out_illegal;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic z, output logic ill,
                         output int edges);
    @(negedge clk);
    in_valid8 = 1'b1; in_op8 = op; in_a8 = a; in_b8 = b;
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_op8 = 4'($urandom); in_a8 = 8'($urandom); in_b8 = 8'($urandom);
    edges = 0;
    while (!out_valid8 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    res = out_result8; z = out_zero8; ill = out_illegal8;
    @(negedge clk) out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 64'd0 ||
        out_zero !== 1'b0 || out_illegal !== 1'b0)
      $display("FAIL reset_state: valid=%b ready=%b res=%h zero=%b ill=%b, required 0 1 0 0 0",
               out_valid, in_ready, out_result, out_zero, out_illegal);
    else n_pass++;
  endtask

  task automatic test_directed;
    logic [3:0]  ops [9]  = '{4'd2, 4'd10, 4'd3, 4'd5, 4'd11, 4'd5, 4'd11, 4'd15, 4'd7};
    logic [63:0] as  [9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                              64'h1_0000_0001, 64'd100, 64'd100, 64'h1234_5678_9ABC_DEF0,
                              64'd5, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] bs  [9]  = '{64'd1, 64'h43, 64'h3, 64'd7, 64'd7, 64'd0, 64'd0, 64'h66, 64'd1};
    logic [63:0] exr [9]  = '{64'd0, 64'hF000_0000_0000_0000, 64'h3_0000_0003, 64'd14, 64'd2,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd0, 64'd1};
    logic        exi [9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] res;
    logic z, ill;
    int edges;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], res, z, ill, edges);
      n_checks++;
      if (res !== exr[i] || z !== (exr[i] == 0) || ill !== exi[i])
        $display("FAIL directed[%0d] op=%b: res=%h zero=%b ill=%b, required %h %b %b",
                 i, ops[i], res, z, ill, exr[i], (exr[i] == 0), exi[i]);
      else n_pass++;
      n_checks++;
      if (edges !== exp_edges(64, ops[i]))
        $display("FAIL directed_latency[%0d]: %0d edges after accept, required %0d",
                 i, edges, exp_edges(64, ops[i]));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [63:0] res;
    logic z, ill, seen;
    int edges;
    run_op(4'd4, 64'h1234, 64'd0, res, z, ill, edges);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd3; in_a = 64'hDEAD_BEEF; in_b = 64'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0)
      $display("FAIL reset_async: valid=%b res=%h, required 0 0", out_valid, out_result);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_zero !== 1'b0 ||
        out_illegal !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_mid_mul: valid=%b res=%h zero=%b ill=%b ready=%b, required 0 0 0 0 1",
               out_valid, out_result, out_zero, out_illegal, in_ready);
    else n_pass++;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL reset_discard: out_valid seen=%b, required 0", seen);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [63:0] exp_r;
    logic ok;
    exp_r = model(64, 4'd4, 64'hA5A5_0000_FFFF_1234, 64'h0F0F_0F0F_0F0F_0F0F);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd4;
    in_a = 64'hA5A5_0000_FFFF_1234; in_b = 64'h0F0F_0F0F_0F0F_0F0F;
    @(posedge clk); #1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== exp_r) ok = 1'b0;
      @(negedge clk);
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_op = 4'($urandom);
      @(posedge clk); #1;
    end
    n_checks++;
    if (ok !== 1'b1)
      $display("FAIL backpressure_hold: valid=%b ready=%b res=%h, required 1 0 %h",
               out_valid, in_ready, out_result, exp_r);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL backpressure_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b, exp_r;
    logic [3:0] op;
    int bad, highs;
    bad = 0; highs = 0;
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      op = (i % 4 == 1) ? 4'd2 : 4'd6;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      if (i % 2 == 1) exp_r = model(64, op, a, b);
      @(posedge clk); #1;
      if (out_valid) highs++;
      if (out_valid !== (i % 2 == 1)) bad++;
      else if (out_valid && out_result !== exp_r) bad++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (bad != 0 || highs != 10)
      $display("FAIL back_to_back: %0d bad cycles, %0d results, required 0 bad 10 results",
               bad, highs);
    else n_pass++;
  endtask

  task automatic test_flush;
    logic [63:0] res;
    logic z, ill, seen;
    int edges;
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd3; in_a = 64'd12345; in_b = 64'd678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_busy: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd2; in_a = 64'd1; in_b = 64'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_done: valid=%b, required 0", out_valid);
    else n_pass++;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 4'd3; in_a = 64'd9; in_b = 64'd9;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    seen = out_valid;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_vs_accept: valid seen=%b ready=%b, required 0 1", seen, in_ready);
    else n_pass++;
    run_op(4'd3, 64'd12345, 64'd678, res, z, ill, edges);
    n_checks++;
    if (res !== 64'd8369910 || edges !== 64)
      $display("FAIL flush_recover: res=%0d edges=%0d, required 8369910 64", res, edges);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [63:0] a, b, res;
    logic [64:0] exp_v;
    logic [3:0] op;
    logic z, ill;
    int edges, sel;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 64'd0 : (sel == 1) ? 64'($urandom_range(1, 300)) : {$urandom, $urandom};
      if (sel == 2) a = 64'($urandom_range(0, 5000));
      exp_v = model(64, op, a, b);
      run_op(op, a, b, res, z, ill, edges);
      n_checks++;
      if (res !== exp_v[63:0] || ill !== exp_v[64] || z !== (exp_v[63:0] == 0) ||
          edges !== exp_edges(64, op))
        $display("FAIL random[%0d] op=%b a=%h b=%h: res=%h ill=%b z=%b edges=%0d, required %h %b %b %0d",
                 i, op, a, b, res, ill, z, edges, exp_v[63:0], exp_v[64], (exp_v[63:0] == 0),
                 exp_edges(64, op));
      else n_pass++;
    end
  endtask

  task automatic test_width8;
    logic [7:0] a, b, res;
    logic [64:0] exp_v;
    logic [3:0] op;
    logic z, ill;
    int edges;
    run_op8(4'd3, 8'hFF, 8'hFF, res, z, ill, edges);
    n_checks++;
    if (res !== 8'h01 || edges !== 8 || ill !== 1'b0)
      $display("FAIL mul8: res=%h edges=%0d ill=%b, required 01 8 0", res, edges, ill);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = (i % 6 == 0) ? 8'd0 : 8'($urandom);
      exp_v = model(8, op, 64'(a), 64'(b));
      run_op8(op, a, b, res, z, ill, edges);
      n_checks++;
      if (res !== exp_v[7:0] || ill !== exp_v[64] || z !== (exp_v[7:0] == 0) ||
          edges !== exp_edges(8, op))
        $display("FAIL random8[%0d] op=%b a=%h b=%h: res=%h ill=%b z=%b edges=%0d, required %h %b %b %0d",
                 i, op, a, b, res, ill, z, edges, exp_v[7:0], exp_v[64], (exp_v[7:0] == 0),
                 exp_edges(8, op));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_mul();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_random();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
